// File: rtl/regfile_sb.sv
// RV32-style integer register file with an issue-side scoreboard of per-register pending-write counters.
// Optional: define REGFILE_WB_BYPASS_EN to forward same-cycle writeback data into the issuing operands.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned PEND_W = 2,
  localparam int unsigned RW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic            wb_valid,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            op_valid,
  output logic [RW-1:0]   op_rd,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            stall
);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [PEND_W-1:0] PendMax = '1;
  localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [PEND_W-1:0] pend_q [NREGS];
  logic [PEND_W-1:0] pend_d [NREGS];

  logic            op_valid_q, op_valid_d;
  logic [RW-1:0]   op_rd_q, op_rd_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;

  logic [6:0]    opcode;
  logic [RW-1:0] rd_idx, rs1_idx, rs2_idx;
  logic          dec_rs1, dec_rs2, dec_rd;
  logic          rs1_used, rs2_used, rd_used;
  logic          rs1_fwd, rs2_fwd;
  logic          rs1_relax, rs2_relax;
  logic          rs1_haz, rs2_haz, rd_full;
  logic          fire;
  logic          wb_en;
  logic          unused_instr_bits;

  assign opcode  = instr[6:0];
  assign rd_idx  = instr[7 +: RW];
  assign rs1_idx = instr[15 +: RW];
  assign rs2_idx = instr[20 +: RW];

  assign unused_instr_bits = ^{instr[31:25], instr[14:12]};

  always_comb begin
    dec_rs1 = 1'b0;
    dec_rs2 = 1'b0;
    dec_rd  = 1'b0;
    case (opcode)
      OpReg: begin
        dec_rs1 = 1'b1;
        dec_rs2 = 1'b1;
        dec_rd  = 1'b1;
      end
      OpImm, OpLoad, OpJalr: begin
        dec_rs1 = 1'b1;
        dec_rd  = 1'b1;
      end
      OpStore, OpBranch: begin
        dec_rs1 = 1'b1;
        dec_rs2 = 1'b1;
      end
      OpLui, OpAuipc, OpJal: begin
        dec_rd = 1'b1;
      end
      default: ;
    endcase
  end

  // x0 never takes part in hazard tracking.
  assign rs1_used = dec_rs1 && (rs1_idx != '0);
  assign rs2_used = dec_rs2 && (rs2_idx != '0);
  assign rd_used  = dec_rd  && (rd_idx  != '0);

  assign wb_en = wb_valid && (wb_rd != '0);

`ifdef REGFILE_WB_BYPASS_EN
  assign rs1_fwd   = wb_en && (wb_rd == rs1_idx);
  assign rs2_fwd   = wb_en && (wb_rd == rs2_idx);
  // The last outstanding write landing this cycle satisfies the dependency.
  assign rs1_relax = rs1_fwd && (pend_q[rs1_idx] == PendOne);
  assign rs2_relax = rs2_fwd && (pend_q[rs2_idx] == PendOne);
`else
  assign rs1_fwd   = 1'b0;
  assign rs2_fwd   = 1'b0;
  assign rs1_relax = 1'b0;
  assign rs2_relax = 1'b0;
`endif

  assign rs1_haz = rs1_used && (pend_q[rs1_idx] != '0) && !rs1_relax;
  assign rs2_haz = rs2_used && (pend_q[rs2_idx] != '0) && !rs2_relax;
  assign rd_full = rd_used && (pend_q[rd_idx] == PendMax);

  assign stall       = instr_valid && (rs1_haz || rs2_haz || rd_full);
  assign instr_ready = !stall;
  assign fire        = instr_valid && !stall;

  always_comb begin
    op_valid_d = fire;
    op_rd_d    = op_rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    if (fire) begin
      op_rd_d = rd_used ? rd_idx : '0;
      if (!rs1_used) begin
        rs1_d = '0;
      end else if (rs1_fwd) begin
        rs1_d = wb_data;
      end else begin
        rs1_d = regs_q[rs1_idx];
      end
      if (!rs2_used) begin
        rs2_d = '0;
      end else if (rs2_fwd) begin
        rs2_d = wb_data;
      end else begin
        rs2_d = regs_q[rs2_idx];
      end
    end
  end

  // Issue increment and writeback decrement on the same register cancel out.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      logic inc;
      logic dec;
      inc       = fire && rd_used && (rd_idx == RW'(i));
      dec       = wb_en && (wb_rd == RW'(i)) && (pend_q[i] != '0);
      pend_d[i] = pend_q[i];
      if (inc && !dec) begin
        pend_d[i] = pend_q[i] + PendOne;
      end else if (dec && !inc) begin
        pend_d[i] = pend_q[i] - PendOne;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        pend_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        pend_q[i] <= pend_d[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_valid_q <= 1'b0;
      op_rd_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else begin
      op_valid_q <= op_valid_d;
      op_rd_q    <= op_rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
    end
  end

  assign op_valid = op_valid_q;
  assign op_rd    = op_rd_q;
  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic against a reference model.
// Define REGFILE_WB_BYPASS_EN for both bench and RTL to exercise the forwarding build.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int RW = 5;
  localparam int PMAX = 3;

  localparam logic [31:0] AddiX10 = 32'h00500513;
  localparam logic [31:0] AddX12 = 32'h00b50633;
  localparam logic [31:0] AddX5x0 = 32'h000002b3;
  localparam logic [31:0] Ecall = 32'h00000073;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic            clock;
  logic            reset_n;
  logic [31:0]     instr;
  logic            instr_valid;
  logic            instr_ready;
  logic            wb_valid;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            op_valid;
  logic [RW-1:0]   op_rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            stall;

  int checks;
  int failures;

  logic [31:0] m_regs [NREGS];
  int          m_pend [NREGS];
  logic        e_valid;
  logic [4:0]  e_rd;
  logic [31:0] e_rs1;
  logic [31:0] e_rs2;

  regfile_sb #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .PEND_W(2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .op_valid   (op_valid),
    .op_rd      (op_rd),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .stall      (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void decode(input logic [31:0] ins, output bit u1, output bit u2,
                                 output bit ud, output int r1, output int r2, output int rd);
    u1 = 0; u2 = 0; ud = 0;
    r1 = int'(ins[19:15]);
    r2 = int'(ins[24:20]);
    rd = int'(ins[11:7]);
    case (ins[6:0])
      7'b0110011: begin u1 = 1; u2 = 1; ud = 1; end
      7'b0010011, 7'b0000011, 7'b1100111: begin u1 = 1; ud = 1; end
      7'b0100011, 7'b1100011: begin u1 = 1; u2 = 1; end
      7'b0110111, 7'b0010111, 7'b1101111: ud = 1;
      default: ;
    endcase
    if (r1 == 0) u1 = 0;
    if (r2 == 0) u2 = 0;
    if (rd == 0) ud = 0;
  endfunction

  function automatic bit src_blocked(input bit u, input int r);
    if (!u || m_pend[r] == 0) return 0;
    if (Bypass && wb_valid && int'(wb_rd) == r && m_pend[r] == 1) return 0;
    return 1;
  endfunction

  function automatic bit model_stall();
    bit u1, u2, ud;
    int r1, r2, rd;
    if (!instr_valid) return 0;
    decode(instr, u1, u2, ud, r1, r2, rd);
    return src_blocked(u1, r1) || src_blocked(u2, r2) || (ud && m_pend[rd] == PMAX);
  endfunction

  function automatic logic [31:0] model_read(input bit u, input int r);
    if (!u) return 32'h0;
    if (Bypass && wb_valid && int'(wb_rd) == r) return wb_data;
    return m_regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 0;
    end
    e_valid = 0; e_rd = 0; e_rs1 = 0; e_rs2 = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit u1, u2, ud, fire, wb;
    int r1, r2, rd, w;
    decode(instr, u1, u2, ud, r1, r2, rd);
    fire = instr_valid && !model_stall();
    w = int'(wb_rd);
    wb = wb_valid && w != 0;
    e_valid = fire;
    if (fire) begin
      e_rd  = ud ? 5'(rd) : 5'd0;
      e_rs1 = model_read(u1, r1);
      e_rs2 = model_read(u2, r2);
    end
    if (wb && m_pend[w] > 0) m_pend[w] = m_pend[w] - 1;
    if (fire && ud) m_pend[rd] = m_pend[rd] + 1;
    if (wb) m_regs[w] = wb_data;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic wv,
                       input logic [4:0] wr, input logic [31:0] wd);
    @(negedge clock);
    instr_valid = v;
    instr = ins;
    wb_valid = wv;
    wb_rd = wr;
    wb_data = wd;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic drain();
    for (int i = 1; i < NREGS; i++) begin
      while (m_pend[i] > 0) begin
        drive(0, 32'h0, 1, 5'(i), $urandom);
        step();
      end
    end
    drive(0, 32'h0, 0, 5'd0, 32'h0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    instr_valid = 0; instr = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++; if (op_valid !== 1'b0) begin failures++;
      $display("FAIL reset_op_valid: got %b expected 0", op_valid); end
    checks++; if (op_rd !== 5'd0) begin failures++;
      $display("FAIL reset_op_rd: got %0d expected 0", op_rd); end
    checks++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin failures++;
      $display("FAIL reset_data: got %h/%h expected 0/0", rs1_data, rs2_data); end
    checks++; if (stall !== 1'b0 || instr_ready !== 1'b1) begin failures++;
      $display("FAIL reset_stall: got stall=%b ready=%b expected 0/1", stall, instr_ready); end
  endtask

  task automatic test_issue();
    drive(1, AddiX10, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++;
      $display("FAIL issue_stall: got %b expected 0", stall); end
    step();
    drive(0, 32'h0, 0, 0, 0);
    checks++; if (op_valid !== 1'b1 || op_rd !== 5'd10 || rs1_data !== 32'h0) begin failures++;
      $display("FAIL issue_ops: got v=%b rd=%0d rs1=%h expected 1/10/0", op_valid, op_rd,
               rs1_data); end
    step();
    checks++; if (op_valid !== 1'b0 || op_rd !== 5'd10) begin failures++;
      $display("FAIL issue_hold: got v=%b rd=%0d expected 0/10", op_valid, op_rd); end
  endtask

  task automatic test_raw();
    drive(1, AddX12, 0, 0, 0);
    checks++; if (stall !== 1'b1 || instr_ready !== 1'b0) begin failures++;
      $display("FAIL raw_stall: got stall=%b ready=%b expected 1/0", stall, instr_ready); end
    step();
    checks++; if (op_valid !== 1'b0) begin failures++;
      $display("FAIL raw_no_issue: got %b expected 0", op_valid); end
    drive(1, AddX12, 1, 5'd10, 32'h46);
    checks++; if (stall !== !Bypass) begin failures++;
      $display("FAIL raw_wb_cycle_stall: got %b expected %b", stall, !Bypass); end
    step();
    if (!Bypass) begin
      checks++; if (op_valid !== 1'b0) begin failures++;
        $display("FAIL raw_wb_cycle_issue: got %b expected 0", op_valid); end
      drive(1, AddX12, 0, 0, 0);
      checks++; if (stall !== 1'b0) begin failures++;
        $display("FAIL raw_after_wb_stall: got %b expected 0", stall); end
      step();
    end
    checks++; if (op_valid !== 1'b1 || op_rd !== 5'd12 || rs1_data !== 32'h46 ||
                  rs2_data !== 32'h0) begin failures++;
      $display("FAIL raw_ops: got v=%b rd=%0d rs1=%h rs2=%h expected 1/12/46/0", op_valid,
               op_rd, rs1_data, rs2_data); end
    drive(0, 32'h0, 0, 0, 0);
    step();
  endtask

  task automatic test_wb_nopend();
    drive(0, 32'h0, 1, 5'd11, 32'h123a);
    step();
    drive(1, AddX12, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++;
      $display("FAIL nopend_stall: got %b expected 0", stall); end
    step();
    checks++; if (op_valid !== 1'b1 || op_rd !== 5'd12 || rs1_data !== 32'h46 ||
                  rs2_data !== 32'h123a) begin failures++;
      $display("FAIL nopend_ops: got v=%b rd=%0d rs1=%h rs2=%h expected 1/12/46/123a",
               op_valid, op_rd, rs1_data, rs2_data); end
    drive(0, 32'h0, 0, 0, 0);
    step();
  endtask

  task automatic test_pend_full();
    for (int k = 0; k < 3; k++) begin
      drive(1, AddiX10, 0, 0, 0);
      checks++; if (stall !== 1'b0) begin failures++;
        $display("FAIL pend_fill_%0d: got stall=%b expected 0", k, stall); end
      step();
    end
    drive(1, AddiX10, 0, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++;
      $display("FAIL pend_full_stall: got %b expected 1", stall); end
    step();
    drive(1, AddiX10, 1, 5'd10, 32'h7);
    checks++; if (stall !== 1'b1) begin failures++;
      $display("FAIL pend_full_wb_stall: got %b expected 1", stall); end
    step();
    drive(1, AddiX10, 1, 5'd10, 32'h8);
    checks++; if (stall !== 1'b0) begin failures++;
      $display("FAIL pend_inc_dec_stall: got %b expected 0", stall); end
    step();
    checks++; if (op_valid !== 1'b1 || op_rd !== 5'd10) begin failures++;
      $display("FAIL pend_inc_dec_ops: got v=%b rd=%0d expected 1/10", op_valid, op_rd); end
    drive(1, AddiX10, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++;
      $display("FAIL pend_refill_stall: got %b expected 0", stall); end
    step();
    drive(1, AddiX10, 0, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++;
      $display("FAIL pend_refull_stall: got %b expected 1", stall); end
    step();
    drain();
  endtask

  task automatic test_x0_ecall();
    drive(0, 32'h0, 1, 5'd0, 32'h02007091);
    step();
    drive(1, AddX5x0, 0, 0, 0);
    step();
    checks++; if (op_valid !== 1'b1 || op_rd !== 5'd5 || rs1_data !== 32'h0 ||
                  rs2_data !== 32'h0) begin failures++;
      $display("FAIL x0_read: got v=%b rd=%0d rs1=%h rs2=%h expected 1/5/0/0", op_valid, op_rd,
               rs1_data, rs2_data); end
    drive(1, Ecall, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++;
      $display("FAIL ecall_stall: got %b expected 0", stall); end
    step();
    checks++; if (op_valid !== 1'b1 || op_rd !== 5'd0) begin failures++;
      $display("FAIL ecall_ops: got v=%b rd=%0d expected 1/0", op_valid, op_rd); end
    drain();
  endtask

  task automatic test_reset_mid();
    drive(1, AddiX10, 0, 0, 0);
    step();
    drive(1, AddX12, 0, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++;
      $display("FAIL midrst_pre_stall: got %b expected 1", stall); end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (op_valid !== 1'b0 || op_rd !== 5'd0 || rs1_data !== 32'h0 ||
                  rs2_data !== 32'h0) begin failures++;
      $display("FAIL midrst_outputs: got v=%b rd=%0d rs1=%h rs2=%h expected all 0", op_valid,
               op_rd, rs1_data, rs2_data); end
    checks++; if (stall !== 1'b0) begin failures++;
      $display("FAIL midrst_stall: got %b expected 0", stall); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    step();
    checks++; if (op_valid !== 1'b1 || op_rd !== 5'd12 || rs1_data !== 32'h0 ||
                  rs2_data !== 32'h0) begin failures++;
      $display("FAIL midrst_release_issue: got v=%b rd=%0d rs1=%h rs2=%h expected 1/12/0/0",
               op_valid, op_rd, rs1_data, rs2_data); end
    drain();
  endtask

  task automatic test_random();
    logic [6:0] ops [11];
    logic [31:0] ins;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0001111};
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 10)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), ins, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom);
      checks++; if (stall !== model_stall() || instr_ready !== !model_stall()) begin failures++;
        $display("FAIL rand_stall[%0d]: got stall=%b ready=%b expected stall=%b", n, stall,
                 instr_ready, model_stall()); end
      step();
      checks++; if (op_valid !== e_valid || op_rd !== e_rd || rs1_data !== e_rs1 ||
                    rs2_data !== e_rs2) begin failures++;
        $display("FAIL rand_ops[%0d]: got v=%b rd=%0d rs1=%h rs2=%h expected %b/%0d/%h/%h", n,
                 op_valid, op_rd, rs1_data, rs2_data, e_valid, e_rd, e_rs1, e_rs2); end
    end
    drain();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_issue();
    test_raw();
    test_wb_nopend();
    test_pend_full();
    test_x0_ecall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
